// File: rtl/dcache_inv_sequencer_pkg.sv
// Shared types and helpers for the data-cache external invalidation sequencer.
package dcache_inv_sequencer_pkg;

  localparam int DCACHE_SUB_LINE_ADDR_W = 2;
  localparam int DCACHE_LINE_KEY_W      = 32 - 2 - DCACHE_SUB_LINE_ADDR_W;

  typedef logic [DCACHE_LINE_KEY_W-1:0] dcache_line_key_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    GAP    = 2'd2
  } dinv_state_t;

  // Line key is the address with the word and sub-line offset bits shifted out.
  function automatic dcache_line_key_t addr_to_key(input logic [31:0] addr);
    return dcache_line_key_t'(addr >> (32 - DCACHE_LINE_KEY_W));
  endfunction

  // Rebuild a line-aligned byte address from a key.
  function automatic logic [31:0] key_to_addr(input dcache_line_key_t key);
    return {key, {(32 - DCACHE_LINE_KEY_W){1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_inv_sequencer_key_fifo.sv
// Small register FIFO of line keys; every entry and its valid bit are
// exposed so the owner can compare a new key against the whole queue at once.
module inv_key_fifo
  import dcache_inv_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  dcache_line_key_t             i_key,
  input  logic                         i_pop,
  output dcache_line_key_t             o_head,
  output dcache_line_key_t [DEPTH-1:0] o_entries,
  output logic             [DEPTH-1:0] o_valid,
  output logic                         o_empty,
  output logic                         o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dcache_line_key_t [DEPTH-1:0] r_mem;
  logic             [DEPTH-1:0] r_vld;
  logic             [PTR_W-1:0] r_wptr;
  logic             [PTR_W-1:0] r_rptr;

  // Ring storage: push writes at the tail, pop retires the head. The owner
  // never pushes when full nor pops when empty, so the two never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem  <= '0;
      r_vld  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + 1'b1;
      end
      if (i_push) begin
        r_mem[r_wptr] <= i_key;
        r_vld[r_wptr] <= 1'b1;
        r_wptr        <= r_wptr + 1'b1;
      end
    end
  end

  assign o_head    = r_mem[r_rptr];
  assign o_entries = r_mem;
  assign o_valid   = r_vld;
  assign o_empty   = ~|r_vld;
  assign o_full    = &r_vld;

endmodule

// File: rtl/dcache_inv_sequencer.sv
// Feeds queued external invalidations into the tag banks' extern_inv port one
// at a time, honouring the two-cycle lookup, the mandatory idle gap, duplicate
// coalescing and fill-starvation hold.
module dcache_inv_sequencer
  import dcache_inv_sequencer_pkg::*;
#(
  parameter int INV_FIFO_DEPTH = 4,
  parameter int STALL_LIMIT    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inv_req_valid,
  input  logic [31:0] inv_req_addr,
  output logic        inv_req_ready,
  input  logic        update,
  output logic        extern_inv,
  output logic [31:0] inv_addr,
  input  logic        extern_inv_complete,
  output logic        fill_hold,
  output logic        inv_done,
  output logic        inv_coalesced,
  output logic        inv_pending
);

  localparam int CNT_W = $clog2(STALL_LIMIT + 1);

  dinv_state_t      r_state, w_state_nxt;
  dcache_line_key_t r_key;
  logic [CNT_W-1:0] r_stall_cnt, w_stall_cnt_nxt;
  logic             r_fill_hold;
  logic             r_coalesced;

  dcache_line_key_t                      w_req_key;
  dcache_line_key_t                      w_head;
  dcache_line_key_t [INV_FIFO_DEPTH-1:0] w_entries;
  logic             [INV_FIFO_DEPTH-1:0] w_valid;
  logic                                  w_empty, w_full;
  logic                                  w_accept, w_match, w_push, w_pop;
  logic                                  w_finish;

  assign w_req_key     = addr_to_key(inv_req_addr);
  assign inv_req_ready = ~w_full & ~rst;
  assign w_accept      = inv_req_valid & inv_req_ready;
  assign w_push        = w_accept & ~w_match;
  assign w_pop         = (r_state == IDLE) & ~w_empty;
  assign w_finish      = (r_state == LOOKUP) & extern_inv_complete;

  // A request is a duplicate if its line is queued or currently being looked up.
  always_comb begin
    w_match = (r_state == LOOKUP) && (r_key == w_req_key);
    for (int i = 0; i < INV_FIFO_DEPTH; i++) begin
      if (w_valid[i] && (w_entries[i] == w_req_key)) w_match = 1'b1;
    end
  end

  inv_key_fifo #(.DEPTH(INV_FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_key     (w_req_key),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_entries (w_entries),
    .o_valid   (w_valid),
    .o_empty   (w_empty),
    .o_full    (w_full)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and lookup outputs; GAP always lasts one cycle so the bank's
  // accessed flag clears before the next address is presented.
  always_comb begin
    w_state_nxt = r_state;
    extern_inv  = 1'b0;
    inv_done    = 1'b0;
    case (r_state)
      IDLE:    if (!w_empty) w_state_nxt = LOOKUP;
      LOOKUP: begin
        extern_inv = 1'b1;
        if (extern_inv_complete) begin
          inv_done    = 1'b1;
          w_state_nxt = GAP;
        end
      end
      GAP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // In-flight key captured at pop and held for the whole lookup.
  always_ff @(posedge clk) begin
    if (rst)        r_key <= '0;
    else if (w_pop) r_key <= w_head;
  end

  assign inv_addr = extern_inv ? key_to_addr(r_key) : 32'h0;

  // Saturating count of consecutive update-blocked lookup cycles.
  always_comb begin
    w_stall_cnt_nxt = '0;
    if ((r_state == LOOKUP) && !extern_inv_complete && update) begin
      if (r_stall_cnt >= CNT_W'(STALL_LIMIT)) w_stall_cnt_nxt = r_stall_cnt;
      else                                     w_stall_cnt_nxt = r_stall_cnt + 1'b1;
    end
  end

  // Stall counter and sticky fill hold; hold releases only when a lookup lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_fill_hold <= 1'b0;
    end else begin
      r_stall_cnt <= w_stall_cnt_nxt;
      if (w_finish) r_fill_hold <= 1'b0;
      else          r_fill_hold <= r_fill_hold | (w_stall_cnt_nxt >= CNT_W'(STALL_LIMIT));
    end
  end

  // Coalesce pulse appears the cycle after the duplicate was accepted.
  always_ff @(posedge clk) begin
    if (rst) r_coalesced <= 1'b0;
    else     r_coalesced <= w_accept & w_match;
  end

  assign fill_hold     = r_fill_hold;
  assign inv_coalesced = r_coalesced;
  assign inv_pending   = (r_state != IDLE) | ~w_empty;

endmodule
